detonator_sequencer: RTL
========================

Name: detonator_sequencer

Overview:
Control sequencer for the numeric-code detonator datapath. It takes the one-hot 10-key pad and the mode buttons, and performs code entry, code setup and code checking with a retry lockout. After arming it runs the fire countdown and drives the digit display and status indicators. All button and key inputs arrive already synchronised to clk.

Parameters:
N_TRIES, 3, mismatches allowed before lockout (1..7)
COUNT_SEC, 9, countdown start value shown on m_disp (1..15)
TICK_CYCLES, 4, clk cycles per countdown step (>=1)
LOCK_CYCLES, 16, clk cycles spent in LOCK (>=1)
DEFAULT_CODE, 16'h2580, stored code after reset, 4 BCD digits, MSD first

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
A  in  10  one-hot keypad, bit i = digit i
setup  in  1  enter code-setup mode
ready  in  1  start code entry
sure  in  1  confirm entered code
fire  in  1  start countdown when armed
wait_t  in  1  abort/disarm
m_disp  out  4  display digit, 4'hF = blank
lt  out  1  armed indicator
bt  out  1  error pulse (one cycle per mismatch)
rt  out  1  locked indicator
lb  out  1  detonate, held until rst

Behaviour:
- Reset: state IDLE, code = DEFAULT_CODE, buffer = 0, digit_cnt = 0, tries = 0, m_disp = 4'hF, lt/bt/rt/lb = 0. rst overrides all other inputs in every state.
- Key press: valid when A has exactly one bit set and A was 0 on the previous cycle. A multi-hot or held value produces no press.
- Digit capture (SET, ENTRY only): buffer <= {buffer[11:0], digit}. digit_cnt saturates at 4. Presses after the 4th digit are ignored.
- Edge detection: sure, fire and ready act on their rising edge. A registered previous value is kept for each.
- Same-cycle priority: rst > wait_t > sure > key press. A key press in the same cycle as sure is dropped.
- States and transitions:
  - IDLE: ready edge -> ENTRY. setup=1 -> SET. In both cases clear buffer and digit_cnt. If both arrive in one cycle, setup wins.
  - SET: sure edge with digit_cnt==4 -> code <= buffer, then IDLE. sure with digit_cnt<4 is ignored. wait_t -> IDLE, code unchanged.
  - ENTRY: sure edge with digit_cnt==4 -> CHECK. sure with digit_cnt<4 is ignored. wait_t -> IDLE; tries is kept.
  - CHECK (1 cycle):
    - buffer==code -> ARMED, tries <= 0.
    - Otherwise tries+1. If it reaches N_TRIES -> LOCK. Else -> ENTRY with bt=1 for this one cycle, and buffer and digit_cnt cleared.
  - ARMED: lt=1. fire edge -> COUNT, cnt <= COUNT_SEC, tick counter <= 0. wait_t -> IDLE.
  - COUNT: lt=1.
    - Each TICK_CYCLES cycles, cnt decrements.
    - The cycle cnt goes 1 -> 0 enters FIRED.
    - wait_t in any COUNT cycle -> IDLE, and no detonation occurs.
  - FIRED: lb=1, lt=0. No exit except rst.
  - LOCK: rt=1. All keys and buttons are ignored, including wait_t. After LOCK_CYCLES cycles -> IDLE with tries <= 0.
- m_disp:
  - SET/ENTRY: last captured digit, or 4'hF when digit_cnt==0.
  - COUNT: cnt.
  - FIRED: 4'h0.
  - Otherwise: 4'hF.
- Output timing: all outputs are registered. A response appears one cycle after the input edge that causes it.

Test Plan:
- After rst: ready, keys 2,5,8,0, release, sure, then fire. Required: lt=1 one cycle after CHECK. m_disp steps 9..1 every 4 cycles. lb=1 and m_disp=0 after 36 cycles of COUNT, and lb holds until rst.
- Wrong code: keys 2,5,8,1 then sure. Required: bt is a 1-cycle pulse, the FSM is back in ENTRY with m_disp=F, lt=0. Three consecutive wrong codes give rt=1 for 16 cycles, then IDLE. ready is ignored during LOCK.
- Setup: setup, keys 1,2,3,4, sure. Next, ready with 2,5,8,0 then sure -> bt pulse. ready with 1,2,3,4 then sure -> lt=1, and the tries count is cleared.
- Boundary inputs:
  - A=10'b00000_00110 (two keys): ignored, digit_cnt unchanged.
  - One key held for 5 cycles: captured once.
  - 5th digit: ignored.
  - sure after only 3 digits: ignored, stays in ENTRY.
- Abort: wait_t while COUNT shows 5 -> IDLE next cycle, lt=0, lb never asserts. rst during COUNT -> all outputs at reset values, and code = 16'h2580 again.

Source files
------------

// File: rtl/detonator_sequencer.sv
// Control sequencer for the keypad-code detonator: code entry, code setup and code check with a
// retry lockout, then the fire countdown. Outputs are registered from next-state values.
module detonator_sequencer #(
  parameter int unsigned N_TRIES      = 3,
  parameter int unsigned COUNT_SEC    = 9,
  parameter int unsigned TICK_CYCLES  = 4,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter logic [15:0] DEFAULT_CODE = 16'h2580
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] A,
  input  logic       setup,
  input  logic       ready,
  input  logic       sure,
  input  logic       fire,
  input  logic       wait_t,
  output logic [3:0] m_disp,
  output logic       lt,
  output logic       bt,
  output logic       rt,
  output logic       lb
);

  typedef enum logic [2:0] {
    StIdle, StSet, StEntry, StCheck, StArmed, StCount, StFired, StLock
  } state_e;

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [15:0]      code_q, code_d;
  logic [15:0]      buffer_q, buffer_d;
  logic [2:0]       digit_cnt_q, digit_cnt_d;
  logic [2:0]       tries_q, tries_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [LockW-1:0] lock_q, lock_d;
  logic [9:0]       a_prev_q;
  logic             sure_prev_q, fire_prev_q, ready_prev_q;
  logic [3:0]       m_disp_q, m_disp_d;
  logic             lt_q, lt_d, bt_q, bt_d, rt_q, rt_d, lb_q, lb_d;

  logic       key_onehot, key_press, sure_edge, fire_edge, ready_edge, mismatch_err;
  logic [3:0] key_digit;

  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (A[i]) key_digit = 4'(i);
    end
  end

  assign key_onehot = (A != 10'd0) && ((A & (A - 10'd1)) == 10'd0);
  assign key_press  = key_onehot && (a_prev_q == 10'd0);
  assign sure_edge  = sure & ~sure_prev_q;
  assign fire_edge  = fire & ~fire_prev_q;
  assign ready_edge = ready & ~ready_prev_q;

  // State register plus datapath and output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      code_q       <= DEFAULT_CODE;
      buffer_q     <= 16'd0;
      digit_cnt_q  <= 3'd0;
      tries_q      <= 3'd0;
      cnt_q        <= 4'd0;
      tick_q       <= '0;
      lock_q       <= '0;
      a_prev_q     <= 10'd0;
      sure_prev_q  <= 1'b0;
      fire_prev_q  <= 1'b0;
      ready_prev_q <= 1'b0;
      m_disp_q     <= 4'hF;
      lt_q         <= 1'b0;
      bt_q         <= 1'b0;
      rt_q         <= 1'b0;
      lb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      buffer_q     <= buffer_d;
      digit_cnt_q  <= digit_cnt_d;
      tries_q      <= tries_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      lock_q       <= lock_d;
      a_prev_q     <= A;
      sure_prev_q  <= sure;
      fire_prev_q  <= fire;
      ready_prev_q <= ready;
      m_disp_q     <= m_disp_d;
      lt_q         <= lt_d;
      bt_q         <= bt_d;
      rt_q         <= rt_d;
      lb_q         <= lb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    buffer_d     = buffer_q;
    digit_cnt_d  = digit_cnt_q;
    tries_d      = tries_q;
    cnt_d        = cnt_q;
    tick_d       = tick_q;
    lock_d       = lock_q;
    mismatch_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        // wait_t outranks the mode buttons, so it blocks leaving IDLE.
        if (!wait_t && (setup || ready_edge)) begin
          state_d     = setup ? StSet : StEntry;
          buffer_d    = 16'd0;
          digit_cnt_d = 3'd0;
        end
      end
      StSet, StEntry: begin
        if (wait_t) begin
          state_d = StIdle;
        end else if (sure_edge) begin
          if (digit_cnt_q == 3'd4) begin
            if (state_q == StSet) begin
              code_d  = buffer_q;
              state_d = StIdle;
            end else begin
              state_d = StCheck;
            end
          end
        end else if (key_press && digit_cnt_q != 3'd4) begin
          buffer_d    = {buffer_q[11:0], key_digit};
          digit_cnt_d = digit_cnt_q + 3'd1;
        end
      end
      StCheck: begin
        if (buffer_q == code_q) begin
          state_d = StArmed;
          tries_d = 3'd0;
        end else begin
          tries_d = tries_q + 3'd1;
          if (({1'b0, tries_q} + 4'd1) >= 4'(N_TRIES)) begin
            state_d = StLock;
            lock_d  = '0;
          end else begin
            state_d      = StEntry;
            mismatch_err = 1'b1;
            buffer_d     = 16'd0;
            digit_cnt_d  = 3'd0;
          end
        end
      end
      StArmed: begin
        if (wait_t) begin
          state_d = StIdle;
        end else if (fire_edge) begin
          state_d = StCount;
          cnt_d   = 4'(COUNT_SEC);
          tick_d  = '0;
        end
      end
      StCount: begin
        if (wait_t) begin
          state_d = StIdle;
        end else if (tick_q == TickLast) begin
          tick_d = '0;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StFired;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StFired: ;
      StLock: begin
        if (lock_q == LockLast) begin
          state_d = StIdle;
          tries_d = 3'd0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    m_disp_d = 4'hF;
    lt_d     = 1'b0;
    rt_d     = 1'b0;
    lb_d     = 1'b0;
    bt_d     = mismatch_err;
    unique case (state_d)
      StSet, StEntry: m_disp_d = (digit_cnt_d == 3'd0) ? 4'hF : buffer_d[3:0];
      StArmed:        lt_d = 1'b1;
      StCount: begin
        lt_d     = 1'b1;
        m_disp_d = cnt_d;
      end
      StFired: begin
        lb_d     = 1'b1;
        m_disp_d = 4'h0;
      end
      StLock:         rt_d = 1'b1;
      default:        m_disp_d = 4'hF;
    endcase
  end

  assign m_disp = m_disp_q;
  assign lt     = lt_q;
  assign bt     = bt_q;
  assign rt     = rt_q;
  assign lb     = lb_q;

endmodule
